fsmc_bus_ctrl: RTL and testbench
================================

FSMC_BUS_CTRL -- requirements
Module: fsmc_bus_ctrl

Interface
- REQ-001 The block SHALL have one parameter, TIMEOUT_CYC, default 16, giving the maximum number of REQ cycles allowed without an ack (legal range 2..255).
- REQ-002 The block SHALL have these ports:
  - clk  in  1  single system clock; all logic on its rising edge.
  - reset_n  in  1  synchronous, active-low reset.
  - bus_valid  in  1  one-cycle pulse: fsmc_interface has completed an MCU transaction.
  - bus_wr  in  1  1 = MCU write, 0 = MCU read.
  - bus_cs  in  4  one-hot peripheral select, decoded from the address.
  - bus_wdata  in  16  write data from the MCU.
  - bus_rdata  out  16  read data returned to fsmc_interface.
  - bus_done  out  1  one-cycle completion pulse.
  - bus_busy  out  1  high whenever the state is not IDLE.
  - per_req  out  4  per-peripheral request, one-hot.
  - per_we  out  1  write enable qualifying per_req.
  - per_wdata  out  16  write data, shared by all peripherals.
  - per_ack  in  4  per-peripheral acknowledge.
  - per_rdata  in  64  slot i read data on bits [16i+15:16i].
  - err_clr  in  1  clears err_flags and err_cnt.
  - err_flags  out  3  sticky flags: [0] decode, [1] timeout, [2] overflow.
  - err_cnt  out  8  saturating error counter.

Function
- REQ-003 The FSM SHALL have exactly four states: IDLE, REQ, DONE and ERR.
- REQ-004 In IDLE, bus_valid with exactly one bus_cs bit set SHALL latch cs, wr and wdata and enter REQ; per_req, per_we and per_wdata SHALL be valid on the next cycle.
- REQ-005 In IDLE, bus_valid with bus_cs zero or multi-hot SHALL enter ERR and set err_flags[0]; no per_req SHALL be asserted.
- REQ-006 In REQ, per_req[i] SHALL be held high until per_ack[i] is sampled high; acks from unselected slots SHALL be ignored.
- REQ-007 An ack sampled in cycle M SHALL give state DONE, per_req = 0 and bus_done = 1 in cycle M+1.
- REQ-008 On a read, bus_rdata SHALL hold the selected per_rdata slice captured on the ack cycle.
- REQ-009 On a write, bus_rdata SHALL be unchanged.
- REQ-010 bus_rdata SHALL hold its value until the next completion.
- REQ-011 DONE and ERR SHALL each last exactly one cycle and assert bus_done.
- REQ-012 After DONE or ERR, the FSM SHALL go to REQ if the pending entry is valid and legal, otherwise to IDLE.
- REQ-013 ERR SHALL drive bus_rdata = 16'hDEAD.
- REQ-014 ERR SHALL increment err_cnt, saturating at 8'hFF.
- REQ-015 The block SHALL contain a one-entry pending buffer: bus_valid while not IDLE with the buffer empty SHALL capture cs, wr and wdata.
- REQ-016 bus_valid while not IDLE with the buffer full SHALL drop the transaction and set err_flags[2].
- REQ-017 If a DONE or ERR cycle consumes the pending entry and a new bus_valid arrives in the same cycle, the new transaction SHALL be captured into the pending buffer, not dropped.
- REQ-018 A pending entry with illegal cs SHALL go through ERR, following the rules of REQ-005.
- REQ-019 If err_clr coincides with a new error, err_clr SHALL take priority.
- REQ-020 bus_busy SHALL equal (state != IDLE).

Reset
- REQ-021 While reset_n is low at a clock edge, the block SHALL enter IDLE and clear the pending buffer and the timeout counter.
- REQ-022 While reset_n is low at a clock edge, every output SHALL be zero (bus_rdata, bus_done, bus_busy, per_req, per_we, per_wdata, err_flags, err_cnt).
- REQ-023 Reset asserted during REQ SHALL drop per_req on the next edge with no bus_done pulse; the in-flight transaction SHALL be discarded.

Configuration
- REQ-024 With FSMC_TIMEOUT_EN defined, a counter SHALL clear on REQ entry and increment each REQ cycle without an ack.
- REQ-025 With FSMC_TIMEOUT_EN defined, the FSM SHALL enter ERR and set err_flags[1] when the counter reaches TIMEOUT_CYC-1 with no ack.
- REQ-026 With FSMC_TIMEOUT_EN defined, an ack in the expiry cycle SHALL win and the FSM SHALL go to DONE.
- REQ-027 Without FSMC_TIMEOUT_EN, REQ SHALL wait indefinitely and err_flags[1] SHALL be tied to 0.

Verification
- REQ-028 Write: bus_valid with cs=4'b0010, wr=1, wdata=16'h0F0F, and ack two cycles later -> per_req=4'b0010, per_we=1, per_wdata=16'h0F0F; bus_done pulses 1 cycle after the ack; bus_rdata unchanged.
- REQ-029 Read: cs=4'b1000, wr=0, per_rdata[63:48]=16'h2321 -> bus_rdata=16'h2321 coincident with bus_done.
- REQ-030 Decode error: cs=4'b0011 -> no per_req; ERR for 1 cycle; bus_rdata=16'hDEAD; err_flags=3'b001; err_cnt=1.
- REQ-031 Timeout (macro on, TIMEOUT_CYC=16, no ack) -> per_req high for exactly 16 cycles, then ERR and err_flags[1]=1; an ack in cycle 16 -> DONE instead.
- REQ-032 Back-to-back: three bus_valid pulses during one REQ -> second completes after the first, third dropped, err_flags[2]=1; reset during the second REQ -> per_req=0 next edge, no bus_done.

Source files
------------

// File: rtl/fsmc_bus_ctrl.sv
// FSMC bus controller: forwards MCU transactions to one-hot peripheral request/ack slots.
// Optional REQ timeout is built when FSMC_TIMEOUT_EN is defined.
module fsmc_bus_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_valid,
  input  logic        bus_wr,
  input  logic [3:0]  bus_cs,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_done,
  output logic        bus_busy,
  output logic [3:0]  per_req,
  output logic        per_we,
  output logic [15:0] per_wdata,
  input  logic [3:0]  per_ack,
  input  logic [63:0] per_rdata,
  input  logic        err_clr,
  output logic [2:0]  err_flags,
  output logic [7:0]  err_cnt
);

  // state | meaning
  // IDLE  | no transaction in flight
  // REQ   | per_req held on the selected slot until its ack
  // DONE  | one-cycle completion, bus_done high
  // ERR   | one-cycle error completion, bus_rdata = DEAD
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cs_q;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic        pend_vld, pend_wr;
  logic [3:0]  pend_cs;
  logic [15:0] pend_wdata;
  logic        src_vld, src_wr, src_legal;
  logic [3:0]  src_cs;
  logic [15:0] src_wdata;
  logic        ack_hit, tmo, dec_err, tmo_err, ovf_err;
  logic [15:0] rd_slice;

  // In DONE/ERR the pending entry wins; with none pending a fresh bus_valid launches directly.
  always_comb begin
    src_vld   = 1'b0;
    src_cs    = bus_cs;
    src_wr    = bus_wr;
    src_wdata = bus_wdata;
    case (state)
      IDLE: src_vld = bus_valid;
      DONE, ERR: begin
        if (pend_vld) begin
          src_vld   = 1'b1;
          src_cs    = pend_cs;
          src_wr    = pend_wr;
          src_wdata = pend_wdata;
        end else begin
          src_vld = bus_valid;
        end
      end
      default: src_vld = 1'b0;
    endcase
  end

  assign src_legal = (src_cs != 4'd0) && ((src_cs & (src_cs - 4'd1)) == 4'd0);
  assign ack_hit   = |(per_ack & cs_q);

  always_comb begin
    rd_slice = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (cs_q[i]) rd_slice = per_rdata[16*i +: 16];
    end
  end

`ifdef FSMC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt;

  assign tmo = (state == REQ) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n)          to_cnt <= 8'd0;
    else if (state != REQ) to_cnt <= 8'd0;
    else                   to_cnt <= to_cnt + 8'd1;
  end
`else
  logic [7:0] unused_to;
  assign unused_to = 8'(TIMEOUT_CYC);
  assign tmo       = 1'b0;
`endif

  assign dec_err = (state != REQ) && src_vld && !src_legal;
  assign tmo_err = (state == REQ) && !ack_hit && tmo;
  assign ovf_err = (state == REQ) && bus_valid && pend_vld;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      REQ: begin
        if (ack_hit)  state_nxt = DONE;
        else if (tmo) state_nxt = ERR;
      end
      default: begin
        if (src_vld) state_nxt = src_legal ? REQ : ERR;
        else         state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    per_req  = (state == REQ) ? cs_q : 4'd0;
    per_we   = (state == REQ) && wr_q;
    bus_done = (state == DONE) || (state == ERR);
    bus_busy = (state != IDLE);
  end

  assign per_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_q       <= 4'd0;
      wr_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      pend_vld   <= 1'b0;
      pend_cs    <= 4'd0;
      pend_wr    <= 1'b0;
      pend_wdata <= 16'h0000;
      bus_rdata  <= 16'h0000;
      err_flags  <= 3'b000;
      err_cnt    <= 8'd0;
    end else begin
      if (state != REQ && src_vld && src_legal) begin
        cs_q    <= src_cs;
        wr_q    <= src_wr;
        wdata_q <= src_wdata;
      end

      // Consuming the entry in DONE/ERR frees the slot for a same-cycle bus_valid.
      if (bus_valid && ((state == REQ && !pend_vld) ||
                        ((state == DONE || state == ERR) && pend_vld))) begin
        pend_vld   <= 1'b1;
        pend_cs    <= bus_cs;
        pend_wr    <= bus_wr;
        pend_wdata <= bus_wdata;
      end else if ((state == DONE || state == ERR) && pend_vld) begin
        pend_vld <= 1'b0;
      end

      if (state == REQ && ack_hit && !wr_q) bus_rdata <= rd_slice;
      else if (state_nxt == ERR)            bus_rdata <= 16'hDEAD;

      if (err_clr) begin
        err_flags <= 3'b000;
        err_cnt   <= 8'd0;
      end else begin
        err_flags <= err_flags | {ovf_err, tmo_err, dec_err};
        if ((dec_err || tmo_err) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fsmc_bus_ctrl.sv
// Table-driven bench for fsmc_bus_ctrl; timeout checks follow FSMC_TIMEOUT_EN.
module tb_fsmc_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, bus_valid, bus_wr, err_clr;
  logic [3:0]  bus_cs, per_ack;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata, per_wdata;
  logic        bus_done, bus_busy, per_we;
  logic [3:0]  per_req;
  logic [63:0] per_rdata;
  logic [2:0]  err_flags;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign per_rdata = {16'h2321, 16'hC2C2, 16'hB1B1, 16'hA0A0};

  fsmc_bus_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus_valid(bus_valid), .bus_wr(bus_wr),
    .bus_cs(bus_cs), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_done(bus_done), .bus_busy(bus_busy), .per_req(per_req), .per_we(per_we),
    .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata),
    .err_clr(err_clr), .err_flags(err_flags), .err_cnt(err_cnt)
  );

  typedef struct {
    logic        rst_n, valid, wr;
    logic [3:0]  cs;
    logic [15:0] wdata;
    logic [3:0]  ack;
    logic        clr;
    logic        done, busy;
    logic [3:0]  req;
    logic        we;
    logic [15:0] pwd, rd;
    logic [2:0]  fl;
    logic [7:0]  cnt;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic valid, logic wr, logic [3:0] cs,
                              logic [15:0] wdata, logic [3:0] ack, logic clr,
                              logic done, logic busy, logic [3:0] req, logic we,
                              logic [15:0] pwd, logic [15:0] rd, logic [2:0] fl,
                              logic [7:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.wr = wr; v.cs = cs; v.wdata = wdata;
    v.ack = ack; v.clr = clr; v.done = done; v.busy = busy; v.req = req;
    v.we = we; v.pwd = pwd; v.rd = rd; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_n = v.rst_n; bus_valid = v.valid; bus_wr = v.wr; bus_cs = v.cs;
    bus_wdata = v.wdata; per_ack = v.ack; err_clr = v.clr;
  endtask

  task automatic chk_out(input vec_t v, input string name);
    logic [49:0] act, exp;
    act = {bus_done, bus_busy, per_req, per_we, per_wdata, bus_rdata, err_flags, err_cnt};
    exp = {v.done, v.busy, v.req, v.we, v.pwd, v.rd, v.fl, v.cnt};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got done=%b busy=%b req=%b we=%b wdata=%h rdata=%h flags=%b cnt=%h, want done=%b busy=%b req=%b we=%b wdata=%h rdata=%h flags=%b cnt=%h",
               name, bus_done, bus_busy, per_req, per_we, per_wdata, bus_rdata, err_flags, err_cnt,
               v.done, v.busy, v.req, v.we, v.pwd, v.rd, v.fl, v.cnt);
    end
  endtask

  task automatic cyc(input vec_t v, input string name);
    drive(v);
    @(posedge clk);
    #1;
    chk_out(v, name);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  vec_t tbl[$];
  vec_t idle_v;

  initial begin
    // rst,val,wr,cs,wdata,ack,clr | done,busy,req,we,per_wdata,rdata,flags,cnt
    tbl.push_back(mk(0,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(0,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(1,1,1,4'b0010,16'h0F0F,4'b0000,0, 0,1,4'b0010,1,16'h0F0F,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0100,0, 0,1,4'b0010,1,16'h0F0F,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0010,0, 1,1,4'b0000,0,16'h0F0F,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0F0F,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(1,1,0,4'b1000,16'h1234,4'b0000,0, 0,1,4'b1000,0,16'h1234,16'h0000,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b1000,0, 1,1,4'b0000,0,16'h1234,16'h2321,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h1234,16'h2321,3'b000,8'h00));
    tbl.push_back(mk(1,1,0,4'b0001,16'h0000,4'b0000,0, 0,1,4'b0001,0,16'h0000,16'h2321,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0001,0, 1,1,4'b0000,0,16'h0000,16'hA0A0,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'hA0A0,3'b000,8'h00));
    tbl.push_back(mk(1,1,1,4'b0100,16'h5A5A,4'b0000,0, 0,1,4'b0100,1,16'h5A5A,16'hA0A0,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0100,0, 1,1,4'b0000,0,16'h5A5A,16'hA0A0,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h5A5A,16'hA0A0,3'b000,8'h00));
    tbl.push_back(mk(1,1,0,4'b0011,16'h0000,4'b0000,0, 1,1,4'b0000,0,16'h5A5A,16'hDEAD,3'b001,8'h01));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h5A5A,16'hDEAD,3'b001,8'h01));
    tbl.push_back(mk(1,1,0,4'b0000,16'h0000,4'b0000,0, 1,1,4'b0000,0,16'h5A5A,16'hDEAD,3'b001,8'h02));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h5A5A,16'hDEAD,3'b001,8'h02));
    tbl.push_back(mk(1,1,0,4'b1100,16'h0000,4'b0000,1, 1,1,4'b0000,0,16'h5A5A,16'hDEAD,3'b000,8'h00));
    tbl.push_back(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h5A5A,16'hDEAD,3'b000,8'h00));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: second queued, third dropped.
    cyc(mk(1,1,1,4'b0001,16'h1111,4'b0000,0, 0,1,4'b0001,1,16'h1111,16'hDEAD,3'b000,8'h00), "b2b_launch");
    cyc(mk(1,1,0,4'b0010,16'h2222,4'b0000,0, 0,1,4'b0001,1,16'h1111,16'hDEAD,3'b000,8'h00), "b2b_pend");
    cyc(mk(1,1,1,4'b0100,16'h3333,4'b0000,0, 0,1,4'b0001,1,16'h1111,16'hDEAD,3'b100,8'h00), "b2b_drop");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0001,0, 1,1,4'b0000,0,16'h1111,16'hDEAD,3'b100,8'h00), "b2b_done1");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,1,4'b0010,0,16'h2222,16'hDEAD,3'b100,8'h00), "b2b_req2");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0010,0, 1,1,4'b0000,0,16'h2222,16'hB1B1,3'b100,8'h00), "b2b_done2");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h2222,16'hB1B1,3'b100,8'h00), "b2b_idle");

    // New bus_valid in a DONE cycle that consumes the pending entry.
    cyc(mk(1,1,0,4'b0001,16'h0000,4'b0000,1, 0,1,4'b0001,0,16'h0000,16'hB1B1,3'b000,8'h00), "cons_launch");
    cyc(mk(1,1,0,4'b1000,16'h0000,4'b0000,0, 0,1,4'b0001,0,16'h0000,16'hB1B1,3'b000,8'h00), "cons_pend");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0001,0, 1,1,4'b0000,0,16'h0000,16'hA0A0,3'b000,8'h00), "cons_done1");
    cyc(mk(1,1,1,4'b0100,16'h4444,4'b0000,0, 0,1,4'b1000,0,16'h0000,16'hA0A0,3'b000,8'h00), "cons_same_cyc");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b1000,0, 1,1,4'b0000,0,16'h0000,16'h2321,3'b000,8'h00), "cons_done2");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,1,4'b0100,1,16'h4444,16'h2321,3'b000,8'h00), "cons_req3");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0100,0, 1,1,4'b0000,0,16'h4444,16'h2321,3'b000,8'h00), "cons_done3");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h4444,16'h2321,3'b000,8'h00), "cons_idle");

    // Reset during the second REQ discards it.
    cyc(mk(1,1,1,4'b0001,16'h7777,4'b0000,0, 0,1,4'b0001,1,16'h7777,16'h2321,3'b000,8'h00), "rst_launch");
    cyc(mk(1,1,0,4'b0010,16'h8888,4'b0000,0, 0,1,4'b0001,1,16'h7777,16'h2321,3'b000,8'h00), "rst_pend");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0001,0, 1,1,4'b0000,0,16'h7777,16'h2321,3'b000,8'h00), "rst_done1");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,1,4'b0010,0,16'h8888,16'h2321,3'b000,8'h00), "rst_req2");
    cyc(mk(0,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'h0000,3'b000,8'h00), "rst_in_req");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0010,0, 0,0,4'b0000,0,16'h0000,16'h0000,3'b000,8'h00), "rst_no_done");

    // Illegal pending entry goes through ERR.
    cyc(mk(1,1,1,4'b0010,16'h9999,4'b0000,0, 0,1,4'b0010,1,16'h9999,16'h0000,3'b000,8'h00), "pill_launch");
    cyc(mk(1,1,0,4'b0101,16'h0000,4'b0000,0, 0,1,4'b0010,1,16'h9999,16'h0000,3'b000,8'h00), "pill_pend");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0010,0, 1,1,4'b0000,0,16'h9999,16'h0000,3'b000,8'h00), "pill_done");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 1,1,4'b0000,0,16'h9999,16'hDEAD,3'b001,8'h01), "pill_err");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h9999,16'hDEAD,3'b001,8'h01), "pill_idle");

    // Counter saturation: one decode error per cycle.
    drive(mk(1,1,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'h0000,3'b000,8'h00));
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
    end
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h9999,16'hDEAD,3'b001,8'hFF), "cnt_sat");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,1, 0,0,4'b0000,0,16'h9999,16'hDEAD,3'b000,8'h00), "cnt_clr");

    idle_v = mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,1,4'b0100,0,16'h0000,16'hDEAD,3'b000,8'h00);
`ifdef FSMC_TIMEOUT_EN
    begin
      int req_cyc;
      cyc(mk(1,1,0,4'b0100,16'h0000,4'b0000,0, 0,1,4'b0100,0,16'h0000,16'hDEAD,3'b000,8'h00), "to_launch");
      req_cyc = 1;
      for (int i = 0; i < 40; i++) begin
        drive(idle_v);
        @(posedge clk);
        #1;
        if (per_req != 4'd0) req_cyc++;
        else break;
      end
      chk_int("to_req_len", req_cyc, 16);
      chk_out(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 1,1,4'b0000,0,16'h0000,16'hDEAD,3'b010,8'h01), "to_err");
      cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'hDEAD,3'b010,8'h01), "to_idle");
      cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,1, 0,0,4'b0000,0,16'h0000,16'hDEAD,3'b000,8'h00), "to_clr");
      cyc(mk(1,1,0,4'b0100,16'h0000,4'b0000,0, 0,1,4'b0100,0,16'h0000,16'hDEAD,3'b000,8'h00), "to2_launch");
      for (int i = 0; i < 15; i++) cyc(idle_v, $sformatf("to2_hold%0d", i));
      cyc(mk(1,0,0,4'b0000,16'h0000,4'b0100,0, 1,1,4'b0000,0,16'h0000,16'hC2C2,3'b000,8'h00), "to2_ack_wins");
    end
`else
    cyc(mk(1,1,0,4'b0100,16'h0000,4'b0000,0, 0,1,4'b0100,0,16'h0000,16'hDEAD,3'b000,8'h00), "nto_launch");
    drive(idle_v);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
    end
    cyc(idle_v, "nto_still_req");
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0100,0, 1,1,4'b0000,0,16'h0000,16'hC2C2,3'b000,8'h00), "nto_done");
`endif
    cyc(mk(1,0,0,4'b0000,16'h0000,4'b0000,0, 0,0,4'b0000,0,16'h0000,16'hC2C2,3'b000,8'h00), "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
